prpg_sequencer: RTL and testbench
=================================

PRPG_SEQUENCER -- requirements
Module: prpg_sequencer

Interface
REQ-001 SHALL have parameter RUNCNT_W, 5, width of the run_L counter (saturating).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  in  1  begin program execution from pc=0 when IDLE.
REQ-005 SHALL have port imem_addr  out  8  instruction address (= pc).
REQ-006 SHALL have port imem_rdata  in  14  instruction {opcode[13:8], shamt[7], funct[6:0]}, valid same cycle as imem_addr.
REQ-007 SHALL have port dp_valid  out  1  command strobe to the LFSR/CA datapath.
REQ-008 SHALL have port dp_op  out  6  opcode of the issued command.
REQ-009 SHALL have port dp_operand  out  8  {shamt,funct} of the issued command.
REQ-010 SHALL have port dp_ready  in  1  datapath acceptance of memory commands.
REQ-011 SHALL have port step_l  out  1  one LFSR shift this cycle.
REQ-012 SHALL have port step_st  out  1  store the next LFSR pattern to M[r_addr] this cycle.
REQ-013 SHALL have port step_c  out  1  one CA generation this cycle.
REQ-014 SHALL have port r_addr  out  8  pattern-memory address register.
REQ-015 SHALL have port run_count  out  RUNCNT_W  number of run_L instructions executed.
REQ-016 SHALL have ports busy, halted, illegal  out  1 each  status flags.

Function
REQ-017 SHALL implement states IDLE, FETCH, EXEC, MEM, STEP_L, STEP_B, HALT; busy=1 in all except IDLE and HALT.
REQ-018 IDLE: start=1 SHALL move to FETCH next cycle; start is ignored in every other state.
REQ-019 FETCH SHALL register imem_rdata into the instruction register and move to EXEC (1 cycle).
REQ-020 Opcodes 000001, 000010, 001100, 001101 (config_tap, init_L, config_C, init_C) SHALL pulse dp_valid for exactly the EXEC cycle, without waiting for dp_ready.
REQ-021 000110 (init_addr) SHALL load r_addr with the operand; 000111 (add_addr) SHALL add it modulo 256; neither asserts dp_valid.
REQ-022 001110 (run_C) SHALL pulse step_c for one cycle in EXEC.
REQ-023 000011 (run_L) SHALL increment run_count (saturating at all-ones). Operand 0 SHALL produce no step. Operand N>0 SHALL enter STEP_L and assert step_l for exactly N consecutive cycles.
REQ-024 001011 (batch_run) SHALL behave as run_L without touching run_count. step_l and step_st SHALL be asserted together for N cycles. r_addr SHALL increment by 1 once, when the instruction completes, including when N=0.
REQ-025 Opcodes 000100, 000101, 001001, 001010, 001111, 010000 SHALL enter MEM. dp_valid, dp_op and dp_operand SHALL be held stable until a cycle with dp_ready=1, which completes the instruction; dp_ready=1 in the first MEM cycle gives 1-cycle completion.
REQ-026 111111 (halt) SHALL enter HALT with halted=1. HALT SHALL be left only by rst_n.
REQ-027 Any other opcode (including 000000) SHALL set illegal (sticky until reset) and execute as a NOP.
REQ-028 Completing a non-halt instruction SHALL increment pc by 1 (255 wraps to 0) and return to FETCH.
REQ-029 Outside their defined cycles, dp_valid, step_l, step_st and step_c SHALL be 0. dp_op and dp_operand SHALL reflect the instruction register at all times.
REQ-030 Step-cycle throughput SHALL be 1 per clock, with no bubble between consecutive step cycles of one instruction.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, pc=0, r_addr=0, run_count=0, instruction register=0, and busy, halted, illegal, dp_valid, step_l, step_st, step_c all 0. This holds in any state, including mid-STEP and mid-MEM; no pending command survives.
REQ-032 After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-033 Program {init_addr 240; run_L 3; halt}, start pulsed: r_addr=240; step_l high exactly 3 consecutive cycles; run_count=1; halted=1; pc stays 2.
REQ-034 batch_run 4 with r_addr=240: step_l=step_st=1 for 4 cycles; r_addr=241 afterwards. batch_run 0: no steps, r_addr increments by 1.
REQ-035 store with dp_ready low 3 cycles then high: dp_valid held 4 cycles with stable op 000100; the next fetch occurs only after acceptance.
REQ-036 add_addr 20 with r_addr=250: r_addr=14. Opcode 000000: illegal=1, pc advances. Run_L executed 33 times: run_count=31.
REQ-037 rst_n low during STEP_L of run_L 100: all strobes 0 immediately, pc=0, IDLE; start restarts the program from address 0.

Source files
------------

// File: rtl/prpg_sequencer.sv
// prpg_sequencer
// Micro-sequencer that fetches 14-bit instructions from an external
// instruction memory and turns them into command strobes for an LFSR /
// cellular-automaton pattern datapath.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin execution from pc=0 (only honoured in IDLE)
//   imem_addr          instruction address (= pc)
//   imem_rdata         instruction {opcode[13:8], shamt[7], funct[6:0]}
//   dp_valid/dp_ready  command handshake to the datapath (see below)
//   dp_op, dp_operand  opcode / operand of the instruction register
//   step_l, step_st    LFSR shift / store-pattern strobes
//   step_c             CA generation strobe
//   r_addr             pattern-memory address register
//   run_count          saturating count of executed run_L instructions
//   busy, halted       status flags decoded from the state register
//   illegal            sticky flag: an undefined opcode was executed
//   dbg_state_o        current FSM state (debug observation)
//
// Handshake: configuration commands pulse dp_valid for a single cycle and
// are not flow-controlled. Memory commands raise dp_valid and keep it,
// dp_op and dp_operand stable until the first rising edge where
// dp_ready=1; that edge completes the transfer and dp_valid drops.
module prpg_sequencer #(
    parameter int RUNCNT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [7:0]          imem_addr,
    input  logic [13:0]         imem_rdata,
    output logic                dp_valid,
    output logic [5:0]          dp_op,
    output logic [7:0]          dp_operand,
    input  logic                dp_ready,
    output logic                step_l,
    output logic                step_st,
    output logic                step_c,
    output logic [7:0]          r_addr,
    output logic [RUNCNT_W-1:0] run_count,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [2:0]          dbg_state_o
);

    localparam logic [5:0] OP_CFG_TAP   = 6'b000001;
    localparam logic [5:0] OP_INIT_L    = 6'b000010;
    localparam logic [5:0] OP_RUN_L     = 6'b000011;
    localparam logic [5:0] OP_MEM_0     = 6'b000100;
    localparam logic [5:0] OP_MEM_1     = 6'b000101;
    localparam logic [5:0] OP_INIT_ADDR = 6'b000110;
    localparam logic [5:0] OP_ADD_ADDR  = 6'b000111;
    localparam logic [5:0] OP_MEM_2     = 6'b001001;
    localparam logic [5:0] OP_MEM_3     = 6'b001010;
    localparam logic [5:0] OP_BATCH     = 6'b001011;
    localparam logic [5:0] OP_CFG_C     = 6'b001100;
    localparam logic [5:0] OP_INIT_C    = 6'b001101;
    localparam logic [5:0] OP_RUN_C     = 6'b001110;
    localparam logic [5:0] OP_MEM_4     = 6'b001111;
    localparam logic [5:0] OP_MEM_5     = 6'b010000;
    localparam logic [5:0] OP_HALT      = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_STEP_L = 3'd4,
        S_STEP_B = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e                state_q;
    logic [7:0]            pc_q;
    logic [13:0]           ir_q;
    logic [7:0]            r_addr_q;
    logic [RUNCNT_W-1:0]   run_count_q;
    logic [7:0]            step_cnt_q;
    logic                  illegal_q;
    logic                  dp_valid_q;
    logic                  step_l_q;
    logic                  step_st_q;
    logic                  step_c_q;

    logic [5:0]            ir_op;
    logic [7:0]            ir_arg;
    logic [7:0]            pc_d;
    logic [7:0]            step_cnt_d;

    assign ir_op      = ir_q[13:8];
    assign ir_arg     = ir_q[7:0];
    assign pc_d       = pc_q + 8'd1;     // 255 wraps to 0
    assign step_cnt_d = ir_arg - 8'd1;   // remaining steps after the first

    // Single-cycle datapath configuration commands.
    function automatic logic is_cfg_op(input logic [5:0] op);
        return (op == OP_CFG_TAP) || (op == OP_INIT_L) ||
               (op == OP_CFG_C)   || (op == OP_INIT_C);
    endfunction

    // Strobe registers are loaded one cycle ahead of the state they belong
    // to, so each strobe is high exactly while the FSM sits in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            r_addr_q    <= '0;
            run_count_q <= '0;
            step_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            dp_valid_q  <= 1'b0;
            step_l_q    <= 1'b0;
            step_st_q   <= 1'b0;
            step_c_q    <= 1'b0;
        end else begin
            dp_valid_q <= 1'b0;
            step_l_q   <= 1'b0;
            step_st_q  <= 1'b0;
            step_c_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    ir_q       <= imem_rdata;
                    dp_valid_q <= is_cfg_op(imem_rdata[13:8]);
                    step_c_q   <= (imem_rdata[13:8] == OP_RUN_C);
                    state_q    <= S_EXEC;
                end

                S_EXEC: begin
                    // Default: instruction completes in this cycle. Branches
                    // that need more cycles override state_q and hold pc_q.
                    state_q <= S_FETCH;
                    pc_q    <= pc_d;
                    case (ir_op)
                        OP_CFG_TAP, OP_INIT_L, OP_CFG_C, OP_INIT_C, OP_RUN_C: begin
                        end
                        OP_INIT_ADDR: r_addr_q <= ir_arg;
                        OP_ADD_ADDR:  r_addr_q <= r_addr_q + ir_arg;
                        OP_RUN_L: begin
                            if (run_count_q != '1) begin
                                run_count_q <= run_count_q + 1'b1;
                            end
                            if (ir_arg != 8'd0) begin
                                state_q    <= S_STEP_L;
                                pc_q       <= pc_q;
                                step_cnt_q <= step_cnt_d;
                                step_l_q   <= 1'b1;
                            end
                        end
                        OP_BATCH: begin
                            if (ir_arg == 8'd0) begin
                                r_addr_q <= r_addr_q + 8'd1;
                            end else begin
                                state_q    <= S_STEP_B;
                                pc_q       <= pc_q;
                                step_cnt_q <= step_cnt_d;
                                step_l_q   <= 1'b1;
                                step_st_q  <= 1'b1;
                            end
                        end
                        OP_MEM_0, OP_MEM_1, OP_MEM_2, OP_MEM_3, OP_MEM_4, OP_MEM_5: begin
                            state_q    <= S_MEM;
                            pc_q       <= pc_q;
                            dp_valid_q <= 1'b1;
                        end
                        OP_HALT: begin
                            state_q <= S_HALT;
                            pc_q    <= pc_q;
                        end
                        default: illegal_q <= 1'b1;
                    endcase
                end

                S_MEM: begin
                    if (dp_ready) begin
                        state_q <= S_FETCH;
                        pc_q    <= pc_d;
                    end else begin
                        dp_valid_q <= 1'b1;
                    end
                end

                S_STEP_L: begin
                    if (step_cnt_q == 8'd0) begin
                        state_q <= S_FETCH;
                        pc_q    <= pc_d;
                    end else begin
                        step_cnt_q <= step_cnt_q - 8'd1;
                        step_l_q   <= 1'b1;
                    end
                end

                S_STEP_B: begin
                    if (step_cnt_q == 8'd0) begin
                        state_q  <= S_FETCH;
                        pc_q     <= pc_d;
                        r_addr_q <= r_addr_q + 8'd1;
                    end else begin
                        step_cnt_q <= step_cnt_q - 8'd1;
                        step_l_q   <= 1'b1;
                        step_st_q  <= 1'b1;
                    end
                end

                S_HALT: begin
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign dp_valid    = dp_valid_q;
    assign dp_op       = ir_op;
    assign dp_operand  = ir_arg;
    assign step_l      = step_l_q;
    assign step_st     = step_st_q;
    assign step_c      = step_c_q;
    assign r_addr      = r_addr_q;
    assign run_count   = run_count_q;
    assign illegal     = illegal_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prpg_sequencer.sv
// Testbench for prpg_sequencer: a behavioural instruction memory, a
// dp_ready responder with per-command wait counts, and a strobe scoreboard.
module tb_prpg_sequencer;
  localparam int RW = 5;

  localparam logic [5:0] OP_ILL0 = 6'b000000;
  localparam logic [5:0] OP_CFG_TAP = 6'b000001;
  localparam logic [5:0] OP_INIT_L = 6'b000010;
  localparam logic [5:0] OP_RUN_L = 6'b000011;
  localparam logic [5:0] OP_INIT_ADDR = 6'b000110;
  localparam logic [5:0] OP_ADD_ADDR = 6'b000111;
  localparam logic [5:0] OP_BATCH = 6'b001011;
  localparam logic [5:0] OP_CFG_C = 6'b001100;
  localparam logic [5:0] OP_INIT_C = 6'b001101;
  localparam logic [5:0] OP_RUN_C = 6'b001110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic dp_ready = 1'b0;
  logic [13:0] imem [256];
  logic [13:0] imem_rdata;
  logic [7:0] imem_addr;
  logic dp_valid;
  logic [5:0] dp_op;
  logic [7:0] dp_operand;
  logic step_l, step_st, step_c;
  logic [7:0] r_addr;
  logic [RW-1:0] run_count;
  logic busy, halted, illegal;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];
  int delay_q[$];
  bit mon_en = 1'b1;
  int cur_run = 0, last_run = 0, cur_vrun = 0, last_vrun = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];

  prpg_sequencer #(.RUNCNT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dp_valid(dp_valid), .dp_op(dp_op), .dp_operand(dp_operand), .dp_ready(dp_ready),
    .step_l(step_l), .step_st(step_st), .step_c(step_c),
    .r_addr(r_addr), .run_count(run_count),
    .busy(busy), .halted(halted), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  function automatic logic [13:0] ins(input logic [5:0] op, input logic [7:0] arg);
    return {op, arg};
  endfunction

  function automatic logic [25:0] ev(input logic v, input logic [5:0] op, input logic [7:0] arg,
                                     input logic sl, input logic sst, input logic sc,
                                     input logic [7:0] ra);
    return {v, op, arg, sl, sst, sc, ra};
  endfunction

  function automatic bit is_mem(input logic [5:0] op);
    return (op == 6'b000100) || (op == 6'b000101) || (op == 6'b001001) ||
           (op == 6'b001010) || (op == 6'b001111) || (op == 6'b010000);
  endfunction

  // Scoreboard: every cycle with an active strobe must match the head of exp_q.
  initial begin
    logic [25:0] obs, e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && (dp_valid || step_l || step_st || step_c)) begin
        obs = {dp_valid, dp_op, dp_operand, step_l, step_st, step_c, r_addr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe got=%h want=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL strobe_event got=%h want=%h", obs, e);
          end
        end
      end
      if (step_l) cur_run++;
      else begin
        if (cur_run > 0) last_run = cur_run;
        cur_run = 0;
      end
      if (dp_valid) cur_vrun++;
      else begin
        if (cur_vrun > 0) last_vrun = cur_vrun;
        cur_vrun = 0;
      end
    end
  end

  // dp_ready responder: each memory command waits the next delay_q count.
  initial begin
    int d;
    bit in_txn;
    d = 0;
    in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && dp_valid && is_mem(dp_op)) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        end else if (d > 0) begin
          d--;
        end
        dp_ready = (d == 0);
      end else begin
        in_txn = 1'b0;
        dp_ready = 1'b0;
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = ins(OP_HALT, 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    exp_q.delete();
    delay_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s_timeout halted=%0b want=1 after %0d cycles", name, halted, budget);
    end
  endtask

  task automatic test_reset();
    clear_imem();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, halted, illegal} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {busy, halted, illegal});
    end
    checks++;
    if ({dp_valid, step_l, step_st, step_c} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b want=0000", {dp_valid, step_l, step_st, step_c});
    end
    checks++;
    if ({imem_addr, r_addr, run_count} !== '0) begin
      errors++; $display("FAIL reset_regs pc=%0d r_addr=%0d run_count=%0d want=0", imem_addr, r_addr, run_count);
    end
    checks++;
    if ({dp_op, dp_operand} !== 14'd0) begin
      errors++; $display("FAIL reset_ir got=%h want=0", {dp_op, dp_operand});
    end
    do_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_without_start state=%0d busy=%b want=0/0", dbg_state, busy);
    end
  endtask

  task automatic test_run_l();
    do_reset();
    clear_imem();
    imem[0] = ins(OP_INIT_ADDR, 8'd240);
    imem[1] = ins(OP_RUN_L, 8'd3);
    imem[2] = ins(OP_HALT, 8'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(1'b0, OP_RUN_L, 8'd3, 1'b1, 1'b0, 1'b0, 8'd240));
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL run_l_busy got=%b want=1", busy);
    end
    wait_halt(100, "run_l");
    checks++;
    if (r_addr !== 8'd240) begin errors++; $display("FAIL run_l_r_addr got=%0d want=240", r_addr); end
    checks++;
    if (run_count !== 5'd1) begin errors++; $display("FAIL run_l_run_count got=%0d want=1", run_count); end
    checks++;
    if (last_run != 3) begin errors++; $display("FAIL run_l_step_len got=%0d want=3", last_run); end
    checks++;
    if (imem_addr !== 8'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL run_l_halt_pc pc=%0d busy=%b want=2/0", imem_addr, busy);
    end
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || imem_addr !== 8'd2) begin
      errors++; $display("FAIL halt_ignores_start halted=%b pc=%0d want=1/2", halted, imem_addr);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL run_l_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_batch();
    int n;
    do_reset();
    clear_imem();
    imem[0] = ins(OP_INIT_ADDR, 8'd240);
    imem[1] = ins(OP_BATCH, 8'd4);
    imem[2] = ins(OP_BATCH, 8'd0);
    imem[3] = ins(OP_HALT, 8'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(ev(1'b0, OP_BATCH, 8'd4, 1'b1, 1'b1, 1'b0, 8'd240));
    pulse_start();
    n = 0;
    while (imem_addr !== 8'd2 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (r_addr !== 8'd241) begin errors++; $display("FAIL batch4_r_addr got=%0d want=241", r_addr); end
    wait_halt(100, "batch");
    checks++;
    if (r_addr !== 8'd242) begin errors++; $display("FAIL batch0_r_addr got=%0d want=242", r_addr); end
    checks++;
    if (last_run != 4) begin errors++; $display("FAIL batch_step_len got=%0d want=4", last_run); end
    checks++;
    if (run_count !== 5'd0 || imem_addr !== 8'd3) begin
      errors++; $display("FAIL batch_misc run_count=%0d pc=%0d want=0/3", run_count, imem_addr);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL batch_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_config();
    logic [5:0] ops [5];
    logic [7:0] args [5];
    do_reset();
    clear_imem();
    ops[0] = OP_CFG_TAP; ops[1] = OP_INIT_L; ops[2] = OP_CFG_C; ops[3] = OP_INIT_C; ops[4] = OP_RUN_C;
    args[0] = 8'h55; args[1] = 8'hAA; args[2] = 8'h81; args[3] = 8'h7F; args[4] = 8'h12;
    for (int i = 0; i < 5; i++) begin
      imem[i] = ins(ops[i], args[i]);
      if (i < 4) exp_q.push_back(ev(1'b1, ops[i], args[i], 1'b0, 1'b0, 1'b0, 8'd0));
      else exp_q.push_back(ev(1'b0, ops[i], args[i], 1'b0, 1'b0, 1'b1, 8'd0));
    end
    pulse_start();
    wait_halt(100, "config");
    checks++;
    if (imem_addr !== 8'd5 || illegal !== 1'b0) begin
      errors++; $display("FAIL config_end pc=%0d illegal=%b want=5/0", imem_addr, illegal);
    end
    checks++;
    if (last_vrun != 1) begin errors++; $display("FAIL config_valid_len got=%0d want=1", last_vrun); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL config_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_mem();
    logic [5:0] ops [6];
    int dly [6];
    int n, held, moved;
    do_reset();
    clear_imem();
    ops[0] = 6'b000100; ops[1] = 6'b000101; ops[2] = 6'b001001;
    ops[3] = 6'b001010; ops[4] = 6'b001111; ops[5] = 6'b010000;
    dly[0] = 3; dly[1] = 0; dly[2] = 1; dly[3] = 0; dly[4] = 2; dly[5] = 0;
    for (int i = 0; i < 6; i++) begin
      imem[i] = ins(ops[i], 8'h30 + 8'(i));
      delay_q.push_back(dly[i]);
      for (int k = 0; k <= dly[i]; k++)
        exp_q.push_back(ev(1'b1, ops[i], 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, 8'd0));
    end
    pulse_start();
    n = 0;
    while (!dp_valid && n < 20) begin @(negedge clk); n++; end
    held = 0;
    moved = 0;
    while (dp_valid && held < 20) begin
      if (imem_addr !== 8'd0) moved++;
      held++;
      @(negedge clk);
    end
    checks++;
    if (held != 4 || moved != 0) begin
      errors++; $display("FAIL store_hold cycles=%0d pc_moves=%0d want=4/0", held, moved);
    end
    checks++;
    if (imem_addr !== 8'd1) begin errors++; $display("FAIL store_next_fetch pc=%0d want=1", imem_addr); end
    wait_halt(200, "mem");
    checks++;
    if (imem_addr !== 8'd6 || last_vrun != 1) begin
      errors++; $display("FAIL mem_end pc=%0d last_valid_len=%0d want=6/1", imem_addr, last_vrun);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mem_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_addr_illegal();
    do_reset();
    clear_imem();
    imem[0] = ins(OP_INIT_ADDR, 8'd250);
    imem[1] = ins(OP_ADD_ADDR, 8'd20);
    imem[2] = ins(OP_ILL0, 8'd0);
    imem[3] = ins(6'b100000, 8'h11);
    pulse_start();
    wait_halt(100, "addr");
    checks++;
    if (r_addr !== 8'd14) begin errors++; $display("FAIL add_addr_wrap got=%0d want=14", r_addr); end
    checks++;
    if (illegal !== 1'b1 || imem_addr !== 8'd4) begin
      errors++; $display("FAIL illegal_nop illegal=%b pc=%0d want=1/4", illegal, imem_addr);
    end
  endtask

  task automatic test_run_count_sat();
    do_reset();
    clear_imem();
    for (int i = 0; i < 33; i++) imem[i] = ins(OP_RUN_L, 8'd0);
    pulse_start();
    wait_halt(200, "sat");
    checks++;
    if (run_count !== 5'd31) begin errors++; $display("FAIL run_count_sat got=%0d want=31", run_count); end
    checks++;
    if (imem_addr !== 8'd33 || exp_q.size() != 0) begin
      errors++; $display("FAIL run_l_zero pc=%0d pending=%0d want=33/0", imem_addr, exp_q.size());
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    do_reset();
    for (int i = 0; i < 256; i++) imem[i] = ins(OP_ADD_ADDR, 8'd1);
    pulse_start();
    n = 0;
    while (imem_addr !== 8'd255 && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (imem_addr === 8'd255 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (imem_addr !== 8'd0 || r_addr !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL pc_wrap pc=%0d r_addr=%0d busy=%b want=0/0/1", imem_addr, r_addr, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    do_reset();
    clear_imem();
    imem[0] = ins(OP_RUN_L, 8'd100);
    mon_en = 1'b0;
    pulse_start();
    n = 0;
    seen = 0;
    while (seen < 10 && n < 100) begin
      @(negedge clk);
      if (step_l) seen++;
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dp_valid, step_l, step_st, step_c} !== 4'b0000 || seen != 10) begin
      errors++; $display("FAIL mid_reset_strobes got=%b steps_seen=%0d want=0000/10",
                         {dp_valid, step_l, step_st, step_c}, seen);
    end
    checks++;
    if (imem_addr !== 8'd0 || dbg_state !== 3'd0 || busy !== 1'b0 || run_count !== 5'd0) begin
      errors++; $display("FAIL mid_reset_state pc=%0d state=%0d busy=%b run_count=%0d want=0",
                         imem_addr, dbg_state, busy, run_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL post_reset_idle got=%0d want=0", dbg_state); end
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) exp_q.push_back(ev(1'b0, OP_RUN_L, 8'd100, 1'b1, 1'b0, 1'b0, 8'd0));
    pulse_start();
    checks++;
    if (imem_addr !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_fetch pc=%0d busy=%b want=0/1", imem_addr, busy);
    end
    wait_halt(300, "restart");
    checks++;
    if (last_run != 100 || run_count !== 5'd1 || exp_q.size() != 0) begin
      errors++; $display("FAIL restart_run steps=%0d run_count=%0d pending=%0d want=100/1/0",
                         last_run, run_count, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_l();
    test_batch();
    test_config();
    test_mem();
    test_addr_illegal();
    test_run_count_sat();
    test_pc_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
